// File: rtl/led_walk_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_walk_ctrl_if
//   Step-command channel between the LED-walk scheduler and the walker.
//   master : scheduler side (drives valid/dir/axis plus queue status)
//   slave  : walker side (drives ready)
// Signals
//   step_valid  head command present
//   step_ready  walker accepts the head command this cycle
//   step_dir    1 = increment (CW), 0 = decrement (CCW)
//   step_axis   0 = x, 1 = y
//   pending     queued command count
//   overflow    sticky event-dropped flag
// ---------------------------------------------------------------------------
interface led_walk_ctrl_if #(
  parameter int PW = 3
);
  logic          step_valid;
  logic          step_ready;
  logic          step_dir;
  logic          step_axis;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output step_valid, step_dir, step_axis, pending, overflow,
    input  step_ready
  );

  modport slave (
    input  step_valid, step_dir, step_axis, pending, overflow,
    output step_ready
  );
endinterface

// File: rtl/led_walk_ctrl.sv
// ---------------------------------------------------------------------------
// led_walk_ctrl
//   Step scheduler for the LED-walk datapath. Raw rotary-encoder lines are
//   synchronised and debounced, full detents are decoded into direction
//   events tagged with the selected axis, and the events are queued in a
//   small FIFO that drains one command at a time over valid/ready.
//
// Parameters
//   DEB_CYCLES  stable cycles before a debounced line flips (>=1)
//   QDEPTH      FIFO depth in commands (power of two, >=2)
//   PW          pending-count width, 2**PW > QDEPTH
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   rot_a     raw encoder channel A (async, bouncy)
//   rot_b     raw encoder channel B (async, bouncy)
//   axis_sel  axis tag sampled when an event is written
//   step      led_walk_ctrl_if.master: step_valid/dir/axis, step_ready,
//             pending, overflow
//
// Build option
//   LED_WALK_CTRL_COALESCE_EN : an event that is the opposite direction of
//   the tail entry on the same axis cancels that entry instead of queuing.
// ---------------------------------------------------------------------------

// Per-channel 2-flop synchroniser + debouncer. Instantiated as an array,
// one instance per encoder line.
module led_walk_deb #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic deb_o
);
  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic          sync1_q, sync2_q, deb_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        // this edge is the DEB_CYCLES-th consecutive mismatch: accept it
        deb_q <= ~deb_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign deb_o = deb_q;
endmodule

module led_walk_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int QDEPTH     = 4,
  parameter int PW         = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rot_a,
  input  logic            rot_b,
  input  logic            axis_sel,
  led_walk_ctrl_if.master step
);
  localparam int AW = $clog2(QDEPTH);

  typedef struct packed {
    logic axis;
    logic dir;
  } cmd_t;

  // ---------------- debounce (bit 1 = A, bit 0 = B) ----------------
  logic [1:0] raw, deb;
  assign raw = {rot_a, rot_b};

  led_walk_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (raw),
    .deb_o (deb)
  );

  // ---------------- quadrature decoder ----------------
  logic [1:0]        st_q;
  logic signed [3:0] acc_q, acc_d, acc_n;
  logic signed [3:0] delta;
  logic              evt_vld_q, evt_vld_d;
  logic              evt_dir_q, evt_dir_d;
  logic              enter00;

  always_comb begin
    delta = 4'sd0;
    case ({st_q, deb})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: delta =  4'sd1;  // CW
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: delta = -4'sd1;  // CCW
      default:                                delta =  4'sd0;  // hold or illegal
    endcase
  end

  always_comb begin
    acc_n     = acc_q + delta;
    enter00   = (deb == 2'b00) && (st_q != 2'b00);
    acc_d     = acc_n;
    evt_vld_d = 1'b0;
    evt_dir_d = 1'b0;
    if (enter00) begin
      // only a full detent in one direction reaches +/-4 by the time we land on 00
      evt_vld_d = (acc_n == 4'sd4) || (acc_n == -4'sd4);
      evt_dir_d = (acc_n == 4'sd4);
      acc_d     = 4'sd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= 2'b00;
      acc_q     <= 4'sd0;
      evt_vld_q <= 1'b0;
      evt_dir_q <= 1'b0;
    end else begin
      st_q      <= deb;
      acc_q     <= acc_d;
      evt_vld_q <= evt_vld_d;
      evt_dir_q <= evt_dir_d;
    end
  end

  // ---------------- command FIFO ----------------
  cmd_t [QDEPTH-1:0] mem_q;
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              pop, push, push_req, full;
  cmd_t              head, new_cmd;

  assign full    = (cnt_q == PW'(QDEPTH));
  assign pop     = (cnt_q != '0) && step.step_ready;
  assign head    = mem_q[rptr_q];
  assign new_cmd = '{axis: axis_sel, dir: evt_dir_q};

`ifdef LED_WALK_CTRL_COALESCE_EN
  logic cancel;
  cmd_t tail;
  assign tail = mem_q[wptr_q - AW'(1)];

  // Opposite step on the same axis annihilates the tail, unless the tail is
  // the head and is leaving this very cycle (then there is nothing to cancel).
  always_comb begin
    cancel = evt_vld_q && (cnt_q != '0) && (tail.axis == axis_sel) &&
             (tail.dir != evt_dir_q) && !((cnt_q == PW'(1)) && pop);
  end

  always_comb begin
    push_req = evt_vld_q && !cancel;
    push     = push_req && (!full || pop);
    ovf_d    = ovf_q | (push_req && full && !pop);
    cnt_d    = cnt_q + PW'(push) - PW'(pop) - PW'(cancel);
    rptr_d   = pop ? rptr_q + AW'(1) : rptr_q;
    wptr_d   = push   ? wptr_q + AW'(1) :
               cancel ? wptr_q - AW'(1) : wptr_q;
  end
`else
  always_comb begin
    push_req = evt_vld_q;
    // a full FIFO still accepts when the head leaves in the same cycle
    push     = push_req && (!full || pop);
    ovf_d    = ovf_q | (push_req && full && !pop);
    cnt_d    = cnt_q + PW'(push) - PW'(pop);
    rptr_d   = pop  ? rptr_q + AW'(1) : rptr_q;
    wptr_d   = push ? wptr_q + AW'(1) : wptr_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) mem_q[wptr_q] <= new_cmd;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    step.step_valid = (cnt_q != '0);
    step.step_dir   = step.step_valid ? head.dir  : 1'b0;
    step.step_axis  = step.step_valid ? head.axis : 1'b0;
    step.pending    = cnt_q;
    step.overflow   = ovf_q;
  end
endmodule

// File: tb/tb_led_walk_ctrl.sv
module tb_led_walk_ctrl;
  localparam int DEB = 4;
  localparam int QD  = 4;
  localparam int PW  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rot_a = 1'b0, rot_b = 1'b0, axis_sel = 1'b0;

  led_walk_ctrl_if #(.PW(PW)) sif ();

  led_walk_ctrl #(.DEB_CYCLES(DEB), .QDEPTH(QD), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b),
    .axis_sel(axis_sel), .step(sif.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] sb[$];   // expected {axis,dir} in issue order

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic phase(input logic a, input logic b, input int n);
    rot_a = a; rot_b = b; tick(n);
  endtask

  task automatic cw_detent();
    phase(1, 0, 10); phase(1, 1, 10); phase(0, 1, 10); phase(0, 0, 10);
  endtask

  task automatic ccw_detent();
    phase(0, 1, 10); phase(1, 1, 10); phase(1, 0, 10); phase(0, 0, 10);
  endtask

  // Scoreboard consumer: every accepted handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sif.step_valid === 1'b1 && sif.step_ready === 1'b1) begin
      if (sb.size() == 0) chk("pop_unexpected", 8'd1, 8'd0);
      else begin
        logic [1:0] e;
        e = sb.pop_front();
        chk("pop_axis", {7'd0, sif.step_axis}, {7'd0, e[1]});
        chk("pop_dir",  {7'd0, sif.step_dir},  {7'd0, e[0]});
      end
    end
  end

  initial begin
    int k;
    logic seen;
    sif.step_ready = 1'b0;
    tick(3);
    // reset state
    chk("rst_valid",   {7'd0, sif.step_valid}, 8'd0);
    chk("rst_pending", {5'd0, sif.pending},    8'd0);
    chk("rst_ovf",     {7'd0, sif.overflow},   8'd0);
    chk("rst_dir",     {7'd0, sif.step_dir},   8'd0);
    rst_n = 1'b1;
    tick(3);

    // 1: clean CW detent, latency to step_valid
    sif.step_ready = 1'b1; axis_sel = 1'b0;
    sb.push_back(2'b01);
    phase(1, 0, 10); phase(1, 1, 10); phase(0, 1, 10);
    rot_a = 1'b0; rot_b = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (sif.step_valid === 1'b1) begin k = i; break; end
    end
    chk("t1_latency", 8'(k), 8'd8);
    tick(1);
    chk("t1_pending0", {5'd0, sif.pending},    8'd0);
    chk("t1_valid0",   {7'd0, sif.step_valid}, 8'd0);
    tick(5);

    // 2: bounce on A never gets through the debouncer
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rot_a = ~rot_a;
      for (int j = 0; j < 2; j++) begin tick(1); seen |= sif.step_valid; end
    end
    rot_a = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(1); seen |= sif.step_valid; end
    chk("t2_no_event", {7'd0, seen}, 8'd0);

    // 3: half turn then reverse: no event; then a clean detent shows acc was cleared
    seen = 1'b0;
    rot_a = 1; rot_b = 0; for (int i = 0; i < 10; i++) begin tick(1); seen |= sif.step_valid; end
    rot_a = 1; rot_b = 1; for (int i = 0; i < 10; i++) begin tick(1); seen |= sif.step_valid; end
    rot_a = 1; rot_b = 0; for (int i = 0; i < 10; i++) begin tick(1); seen |= sif.step_valid; end
    rot_a = 0; rot_b = 0; for (int i = 0; i < 20; i++) begin tick(1); seen |= sif.step_valid; end
    chk("t3_no_event", {7'd0, seen}, 8'd0);
    axis_sel = 1'b1;
    sb.push_back(2'b11);
    cw_detent();
    tick(5);
    chk("t3_after_cw_pending", {5'd0, sif.pending}, 8'd0);
    chk("t3_sb_empty", 8'(sb.size()), 8'd0);

    // 4: six CCW detents with ready low -> full + overflow
    sif.step_ready = 1'b0; axis_sel = 1'b1;
    for (int d = 0; d < 6; d++) begin
      if (sb.size() < QD) sb.push_back(2'b10);
      ccw_detent();
    end
    tick(2);
    chk("t4_pending", {5'd0, sif.pending},  8'd4);
    chk("t4_ovf",     {7'd0, sif.overflow}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t4_head_axis", {7'd0, sif.step_axis}, 8'd1);
      chk("t4_head_dir",  {7'd0, sif.step_dir},  8'd0);
      tick(1);
    end
    sif.step_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_valid", {7'd0, sif.step_valid}, 8'd1);
      tick(1);
    end
    chk("t4_drained", {7'd0, sif.step_valid}, 8'd0);
    chk("t4_ovf_sticky", {7'd0, sif.overflow}, 8'd1);
    sif.step_ready = 1'b0;

    // 5: full FIFO with a pop in the event cycle
    rst_n = 1'b0; tick(1); rst_n = 1'b1; sb.delete(); tick(2);
    axis_sel = 1'b0;
    for (int d = 0; d < 4; d++) begin sb.push_back(2'b01); cw_detent(); end
    chk("t5_full", {5'd0, sif.pending}, 8'd4);
    chk("t5_ovf0", {7'd0, sif.overflow}, 8'd0);
    sb.push_back(2'b01);
    phase(1, 0, 10); phase(1, 1, 10); phase(0, 1, 10);
    rot_a = 1'b0; rot_b = 1'b0;
    tick(7);
    sif.step_ready = 1'b1;
    tick(1);
    sif.step_ready = 1'b0;
    chk("t5_pending", {5'd0, sif.pending},  8'd4);
    chk("t5_ovf",     {7'd0, sif.overflow}, 8'd0);
    tick(5);
    chk("t5_pending_hold", {5'd0, sif.pending}, 8'd4);

    // 6: overflow, pop to 3, reset mid-handshake
    cw_detent();
    chk("t6_ovf", {7'd0, sif.overflow}, 8'd1);
    sif.step_ready = 1'b1; tick(1); sif.step_ready = 1'b0;
    chk("t6_pending3", {5'd0, sif.pending}, 8'd3);
    rst_n = 1'b0; #1;
    chk("t6_rst_valid",   {7'd0, sif.step_valid}, 8'd0);
    chk("t6_rst_pending", {5'd0, sif.pending},    8'd0);
    chk("t6_rst_ovf",     {7'd0, sif.overflow},   8'd0);
    sb.delete();
    tick(1); rst_n = 1'b1; tick(3);
    chk("t6_after_valid", {7'd0, sif.step_valid}, 8'd0);

`ifdef LED_WALK_CTRL_COALESCE_EN
    // CW then CCW on the same axis cancel out
    sif.step_ready = 1'b0; axis_sel = 1'b0;
    cw_detent();
    chk("co_one", {5'd0, sif.pending}, 8'd1);
    ccw_detent();
    chk("co_pending", {5'd0, sif.pending},  8'd0);
    chk("co_ovf",     {7'd0, sif.overflow}, 8'd0);
`endif

    chk("sb_final_empty", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
